mem_access_unit: RTL and testbench

- Parametrised load/store unit for the MEM stage.
- Accepts one memory request at a time from EX/MEM over a valid/ready handshake and drives a variable-latency RAM port (enable, byte-lane write strobes, aligned address, lane-shifted write data). Completion is signalled by RAM ack.
- Returns the load result to WB already lane-extracted and sign/zero-extended.
- Adds what the previous combinational stage lacked: wait-state support, misalignment detection with no RAM access, bus timeout, and a pipeline stall output.

---
 rtl/mem_access_unit_pkg.sv | 29 ++
 rtl/mem_access_unit_if.sv | 49 ++++
 rtl/mem_lane_align.sv | 40 ++++
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: size codes, FSM
// encoding, bus width defaults and the alignment rule.
package mem_access_unit_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // A dword is only a legal size on a 64-bit bus.
    function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                           input logic [1:0] size,
                                           input logic       dw64);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return addr_lo[0];
            SIZE_W:  return |addr_lo[1:0];
            default: return !dw64 || (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bus and RAM-side port of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
interface mem_access_req_if import mem_access_unit_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_ext;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_misalign;
    logic              resp_buserr;
    logic              stall;

    modport master (
        output req_valid, req_write, req_ext, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_buserr, stall
    );
    modport slave (
        input  req_valid, req_write, req_ext, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign, resp_buserr, stall
    );
endinterface

interface mem_access_ram_if import mem_access_unit_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();
    logic                  ram_en;
    logic [DATA_W/8-1:0]   ram_write_en;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_write_data;
    logic [DATA_W-1:0]     ram_read_data;
    logic                  ram_ack;

    modport master (
        output ram_en, ram_write_en, ram_addr, ram_write_data,
        input  ram_read_data, ram_ack
    );
    modport slave (
        input  ram_en, ram_write_en, ram_addr, ram_write_data,
        output ram_read_data, ram_ack
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/shift and load extract/extend.
// Kept free of state so a cache fill path can reuse it.
module mem_lane_align import mem_access_unit_pkg::*; #(
    parameter  int DATA_W = DATA_W_DEF,
    localparam int NL     = DATA_W / 8,
    localparam int LW     = $clog2(NL)
) (
    input  logic [1:0]        size_i,
    input  logic [LW-1:0]     lane_i,
    input  logic              ext_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [NL-1:0]     strb_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic [NL-1:0]     mask;
    logic [DATA_W-1:0] shifted;
    logic              sgn;
    int                nbits;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NL; i++) mask[i] = (i < (1 << size_i));
        strb_o  = mask << lane_i;
        wdata_o = wdata_i << {lane_i, 3'b000};

        shifted = rdata_i >> {lane_i, 3'b000};
        nbits   = 8 << size_i;
        case (size_i)
            SIZE_B:  sgn = shifted[7];
            SIZE_H:  sgn = shifted[15];
            SIZE_W:  sgn = shifted[31];
            default: sgn = shifted[DATA_W-1];
        endcase
        // Bits above the access size are filled with the sign or zero.
        for (int i = 0; i < DATA_W; i++)
            rdata_o[i] = (i < nbits) ? shifted[i] : (ext_i & sgn);
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one request at a time, variable-latency RAM port,
// misalignment rejection and ack timeout.
module mem_access_unit import mem_access_unit_pkg::*; #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_access_req_if.slave         req_bus,
    mem_access_ram_if.master        ram_bus,
    output logic [1:0]              dbg_state_o
);
    localparam int NL = DATA_W / 8;
    localparam int LW = $clog2(NL);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic              ext_q, ext_d, write_q, write_d;
    logic              ram_en_q, ram_en_d;
    logic [NL-1:0]     ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              resp_valid_q, resp_valid_d, mis_q, mis_d, berr_q, berr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              idle, accept, mis;
    logic [1:0]        al_size;
    logic [LW-1:0]     al_lane;
    logic              al_ext;
    logic [NL-1:0]     al_strb;
    logic [DATA_W-1:0] al_wdata, al_rdata;

    assign idle   = (state_q == ST_IDLE);
    assign accept = req_bus.req_valid && idle;
    assign mis    = is_misaligned(req_bus.req_addr[2:0], req_bus.req_size, DATA_W == 64);

    // In IDLE the aligner sees the incoming request; afterwards the latched one.
    assign al_size = idle ? req_bus.req_size : size_q;
    assign al_lane = idle ? req_bus.req_addr[LW-1:0] : lane_q;
    assign al_ext  = idle ? req_bus.req_ext : ext_q;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size_i (al_size),
        .lane_i (al_lane),
        .ext_i  (al_ext),
        .wdata_i(req_bus.req_wdata),
        .rdata_i(ram_bus.ram_read_data),
        .strb_o (al_strb),
        .wdata_o(al_wdata),
        .rdata_o(al_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        lane_d      = lane_q;
        ext_d       = ext_q;
        write_d     = write_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        resp_valid_d = 1'b0;
        mis_d        = 1'b0;
        berr_d       = 1'b0;
        rdata_d      = '0;
        case (state_q)
            ST_IDLE: if (accept) begin
                size_d  = req_bus.req_size;
                lane_d  = req_bus.req_addr[LW-1:0];
                ext_d   = req_bus.req_ext;
                write_d = req_bus.req_write;
                if (mis) begin
                    resp_valid_d = 1'b1;
                    mis_d        = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    ram_en_d    = 1'b1;
                    ram_we_d    = req_bus.req_write ? al_strb : '0;
                    ram_addr_d  = {req_bus.req_addr[ADDR_W-1:LW], {LW{1'b0}}};
                    ram_wdata_d = al_wdata;
                    cnt_d       = '0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: if (ram_bus.ram_ack) begin
                ram_en_d     = 1'b0;
                ram_we_d     = '0;
                resp_valid_d = 1'b1;
                rdata_d      = write_q ? '0 : al_rdata;
                state_d      = ST_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                ram_en_d     = 1'b0;
                ram_we_d     = '0;
                resp_valid_d = 1'b1;
                berr_d       = 1'b1;
                state_d      = ST_RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            size_q       <= '0;
            lane_q       <= '0;
            ext_q        <= 1'b0;
            write_q      <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            mis_q        <= 1'b0;
            berr_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            ext_q        <= ext_d;
            write_q      <= write_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            resp_valid_q <= resp_valid_d;
            mis_q        <= mis_d;
            berr_q       <= berr_d;
            rdata_q      <= rdata_d;
        end
    end

    assign req_bus.req_ready      = idle;
    assign req_bus.stall          = (req_bus.req_valid && !idle) || !idle;
    assign req_bus.resp_valid     = resp_valid_q;
    assign req_bus.resp_rdata     = rdata_q;
    assign req_bus.resp_misalign  = mis_q;
    assign req_bus.resp_buserr    = berr_q;
    assign ram_bus.ram_en         = ram_en_q;
    assign ram_bus.ram_write_en   = ram_we_q;
    assign ram_bus.ram_addr       = ram_addr_q;
    assign ram_bus.ram_write_data = ram_wdata_q;
    assign dbg_state_o            = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit on a 32-bit and a 64-bit instance (TIMEOUT = 4).
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sel, v, wr, ext, ack;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata, rd;
    logic [1:0]  st32, st64;

    mem_access_req_if #(.DATA_W(32), .ADDR_W(32)) q32 ();
    mem_access_ram_if #(.DATA_W(32), .ADDR_W(32)) m32 ();
    mem_access_req_if #(.DATA_W(64), .ADDR_W(32)) q64 ();
    mem_access_ram_if #(.DATA_W(64), .ADDR_W(32)) m64 ();

    assign q32.req_valid = v && !sel;
    assign q32.req_write = wr;
    assign q32.req_ext   = ext;
    assign q32.req_size  = size;
    assign q32.req_addr  = addr;
    assign q32.req_wdata = wdata[31:0];
    assign m32.ram_read_data = rd[31:0];
    assign m32.ram_ack   = ack && !sel;
    assign q64.req_valid = v && sel;
    assign q64.req_write = wr;
    assign q64.req_ext   = ext;
    assign q64.req_size  = size;
    assign q64.req_addr  = addr;
    assign q64.req_wdata = wdata;
    assign m64.ram_read_data = rd;
    assign m64.ram_ack   = ack && sel;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) u32 (
        .clk(clk), .rst(rst), .req_bus(q32), .ram_bus(m32), .dbg_state_o(st32));
    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) u64 (
        .clk(clk), .rst(rst), .req_bus(q64), .ram_bus(m64), .dbg_state_o(st64));

    typedef struct packed {
        logic        dut;
        logic [63:0] rdata;
        logic        mis;
        logic        berr;
        logic [31:0] cyc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_resp(input logic dut, input logic [63:0] rdata,
                              input logic mis, input logic berr);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: dut %0d got resp_valid at cycle %0d, expected none", dut, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.dut !== dut || e.rdata !== rdata || e.mis !== mis || e.berr !== berr
                || e.cyc != 32'(cyc)) begin
                errors++;
                $display("FAIL resp: got dut %0d rdata 0x%0h mis %0b berr %0b cyc %0d, expected dut %0d rdata 0x%0h mis %0b berr %0b cyc %0d",
                         dut, rdata, mis, berr, cyc, e.dut, e.rdata, e.mis, e.berr, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (q32.resp_valid) check_resp(1'b0, {32'b0, q32.resp_rdata}, q32.resp_misalign, q32.resp_buserr);
        if (q64.resp_valid) check_resp(1'b1, q64.resp_rdata, q64.resp_misalign, q64.resp_buserr);
    end

    // ack_k: cycle of the ram_ack after acceptance (0 = never acks).
    task automatic txn(input logic s, input logic w, input logic e, input logic [1:0] sz,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rdv,
                       input int ack_k, input logic mis_exp, input logic [63:0] exp_rdata,
                       input logic berr_exp, input logic [31:0] exp_addr,
                       input logic [7:0] exp_we, input logic [63:0] exp_wd);
        int lat;
        logic [63:0] ob;
        @(negedge clk);
        sel = s; v = 1'b1; wr = w; ext = e; size = sz; addr = a; wdata = wd; rd = rdv; ack = 1'b0;
        check("req_ready", s ? q64.req_ready : q32.req_ready, 1);
        lat = mis_exp ? 1 : (ack_k > 0 ? ack_k + 1 : TO + 1);
        exp_q.push_back('{dut: s, rdata: exp_rdata, mis: mis_exp, berr: berr_exp, cyc: 32'(cyc + lat)});
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            v = 1'b0;
            ack = (ack_k == j);
            check("stall", s ? q64.stall : q32.stall, 1);
            if (mis_exp) begin
                check("ram_en_mis", s ? m64.ram_en : m32.ram_en, 0);
            end else if (j == 1) begin
                check("ram_en", s ? m64.ram_en : m32.ram_en, 1);
                check("ram_addr", s ? m64.ram_addr : m32.ram_addr, exp_addr);
                ob = s ? {56'b0, m64.ram_write_en} : {60'b0, m32.ram_write_en};
                check("ram_write_en", ob, exp_we);
                ob = s ? m64.ram_write_data : {32'b0, m32.ram_write_data};
                check("ram_write_data", ob, exp_wd);
            end
        end
        ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; sel = 0; v = 0; wr = 0; ext = 0; ack = 0; size = 0; addr = 0; wdata = 0; rd = 0;
        repeat (3) @(negedge clk);
        check("rst_state32", st32, ST_IDLE);
        check("rst_ram_en32", m32.ram_en, 0);
        check("rst_ram_addr64", m64.ram_addr, 0);
        check("rst_resp_valid32", q32.resp_valid, 0);
        rst = 1'b1;

        // 32-bit unit
        txn(0, 1, 0, SIZE_B, 32'h1003, 64'hAB, 64'h0, 1, 0, 64'h0, 0, 32'h1000, 8'h8, 64'hAB00_0000);
        txn(0, 0, 1, SIZE_H, 32'h2002, 64'h0, 64'h8001_1234, 4, 0, 64'hFFFF_8001, 0, 32'h2000, 8'h0, 64'h0);
        txn(0, 0, 0, SIZE_W, 32'h3001, 64'h0, 64'h0, 1, 1, 64'h0, 0, 32'h0, 8'h0, 64'h0);
        txn(0, 0, 0, SIZE_D, 32'h3000, 64'h0, 64'h0, 1, 1, 64'h0, 0, 32'h0, 8'h0, 64'h0);
        txn(0, 0, 0, SIZE_W, 32'h0100, 64'h0, 64'hFFFF_FFFF, 0, 0, 64'h0, 1, 32'h0100, 8'h0, 64'h0);
        txn(0, 0, 0, SIZE_W, 32'h0104, 64'h0, 64'hDEAD_BEEF, 4, 0, 64'hDEAD_BEEF, 0, 32'h0104, 8'h0, 64'h0);
        txn(0, 0, 1, SIZE_B, 32'h0201, 64'h0, 64'h0000_8000, 2, 0, 64'hFFFF_FF80, 0, 32'h0200, 8'h0, 64'h0);
        txn(0, 1, 0, SIZE_H, 32'h0302, 64'h1234, 64'h0, 1, 0, 64'h0, 0, 32'h0300, 8'hC, 64'h1234_0000);
        txn(0, 0, 0, SIZE_H, 32'h0305, 64'h0, 64'h0, 1, 1, 64'h0, 0, 32'h0, 8'h0, 64'h0);

        // 64-bit unit
        txn(1, 1, 0, SIZE_D, 32'h0010, 64'h1122_3344_5566_7788, 64'h0, 1, 0, 64'h0, 0,
            32'h0010, 8'hFF, 64'h1122_3344_5566_7788);
        txn(1, 0, 0, SIZE_H, 32'h0016, 64'h0, 64'hBEEF_0000_0000_0000, 2, 0, 64'hBEEF, 0,
            32'h0010, 8'h0, 64'h0);
        txn(1, 0, 1, SIZE_W, 32'h0014, 64'h0, 64'h8765_4321_0000_0000, 1, 0, 64'hFFFF_FFFF_8765_4321, 0,
            32'h0010, 8'h0, 64'h0);
        txn(1, 1, 0, SIZE_B, 32'h001F, 64'h5A, 64'h0, 3, 0, 64'h0, 0, 32'h0018, 8'h80, 64'h5A00_0000_0000_0000);

        // reset in the middle of an access, then a stray ack
        @(negedge clk);
        sel = 0; v = 1; wr = 0; ext = 0; size = SIZE_W; addr = 32'h40; rd = 64'h1234_5678;
        @(negedge clk);
        v = 0;
        check("rst_mid_ram_en_before", m32.ram_en, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid_state", st32, ST_IDLE);
        check("rst_mid_ram_en", m32.ram_en, 0);
        check("rst_mid_ram_addr", m32.ram_addr, 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("stray_ack_state", st32, ST_IDLE);
        check("stray_ack_ram_en", m32.ram_en, 0);
        @(negedge clk);
        check("stray_ack_resp_valid", q32.resp_valid, 0);

        txn(0, 0, 0, SIZE_W, 32'h0048, 64'h0, 64'hCAFE_F00D, 1, 0, 64'hCAFE_F00D, 0, 32'h0048, 8'h0, 64'h0);

        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
